// File: rtl/fb_wr_scheduler.sv
// Frame-buffer write scheduler: picks a free frame slot at each start of frame,
// walks the per-line destination address and forwards the video stream to the
// stream-to-burst writer with zero latency.
module fb_wr_scheduler #(
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned MAX_PKT_SIZE_WIDTH = 11,
    parameter int unsigned LINES_WIDTH        = 12,
    parameter int unsigned NUM_SLOTS          = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    // upstream video (tuser = start of frame, tlast = end of line)
    input  logic [DATA_WIDTH-1:0]         video_i_tdata,
    input  logic [DATA_WIDTH/8-1:0]       video_i_tstrb,
    input  logic [DATA_WIDTH/8-1:0]       video_i_tkeep,
    input  logic                          video_i_tlast,
    input  logic                          video_i_tuser,
    input  logic                          video_i_tvalid,
    output logic                          video_i_tready,

    // towards the stream-to-burst writer
    output logic [DATA_WIDTH-1:0]         video_o_tdata,
    output logic [DATA_WIDTH/8-1:0]       video_o_tstrb,
    output logic [DATA_WIDTH/8-1:0]       video_o_tkeep,
    output logic                          video_o_tlast,
    output logic                          video_o_tuser,
    output logic                          video_o_tvalid,
    input  logic                          video_o_tready,

    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [ADDR_WIDTH-1:0]         frame_stride_i,
    input  logic [ADDR_WIDTH-1:0]         line_stride_i,
    input  logic [MAX_PKT_SIZE_WIDTH-1:0] line_size_i,
    input  logic [LINES_WIDTH-1:0]        frame_lines_i,
    input  logic [$clog2(NUM_SLOTS)-1:0]  rd_slot_i,

    output logic [ADDR_WIDTH-1:0]         addr_o,
    output logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_o,
    output logic [$clog2(NUM_SLOTS)-1:0]  wr_slot_o,
    output logic [$clog2(NUM_SLOTS)-1:0]  done_slot_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

    typedef enum logic {
        WAIT_SOF_S = 1'b0,
        RUN_S      = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;

    logic                          r_line_first;
    logic [LINES_WIDTH-1:0]        r_line_cnt;
    logic [LINES_WIDTH-1:0]        r_lines;
    logic [ADDR_WIDTH-1:0]         r_line_stride;
    logic [ADDR_WIDTH-1:0]         r_addr;
    logic [MAX_PKT_SIZE_WIDTH-1:0] r_pkt_size;
    logic [SLOT_W-1:0]             r_wr_slot;
    logic [SLOT_W-1:0]             r_done_slot;
    logic                          r_done;
    logic                          r_err;

    logic                          w_sof;
    logic                          w_last_line;
    logic                          w_in_tready;
    logic                          w_out_tvalid;
    logic                          w_hs_in;
    logic                          w_start;
    logic                          w_abort;
    logic                          w_line_adv;
    logic                          w_frame_done;
    logic [SLOT_W-1:0]             w_slot_inc1;
    logic [SLOT_W-1:0]             w_slot_inc2;
    logic [SLOT_W-1:0]             w_next_slot;
    logic [ADDR_WIDTH-1:0]         w_frame_addr;

    // A start-of-frame beat is a tuser beat that opens a line
    assign w_sof       = video_i_tvalid && video_i_tuser && r_line_first;
    assign w_last_line = (r_line_cnt >= (r_lines - LINES_WIDTH'(1)));
    assign w_hs_in     = video_i_tvalid && w_in_tready;

    // Next slot skips the one held by the reader
    assign w_slot_inc1  = (r_wr_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : (r_wr_slot + SLOT_W'(1));
    assign w_slot_inc2  = (w_slot_inc1 == SLOT_W'(NUM_SLOTS - 1)) ? '0 : (w_slot_inc1 + SLOT_W'(1));
    assign w_next_slot  = (w_slot_inc1 == rd_slot_i) ? w_slot_inc2 : w_slot_inc1;
    assign w_frame_addr = base_addr_i + (ADDR_WIDTH'(w_next_slot) * frame_stride_i);

    // Zero-latency pass-through of the payload; only valid/ready are steered
    assign video_o_tdata  = video_i_tdata;
    assign video_o_tstrb  = video_i_tstrb;
    assign video_o_tkeep  = video_i_tkeep;
    assign video_o_tlast  = video_i_tlast;
    assign video_o_tuser  = video_i_tuser;
    assign video_o_tvalid = w_out_tvalid;
    assign video_i_tready = w_in_tready;

    assign addr_o      = r_addr;
    assign pkt_size_o  = r_pkt_size;
    assign wr_slot_o   = r_wr_slot;
    assign done_slot_o = r_done_slot;
    assign done_o      = r_done;
    assign err_o       = r_err;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= WAIT_SOF_S;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake steering and frame/line events
    always_comb begin
        w_state_nxt  = r_state;
        w_in_tready  = 1'b0;
        w_out_tvalid = 1'b0;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        w_line_adv   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            WAIT_SOF_S: begin
                // drop everything until SOF; the SOF beat is held for RUN_S
                w_in_tready = !w_sof;
                if (w_sof) begin
                    w_start     = 1'b1;
                    w_state_nxt = RUN_S;
                end
            end
            RUN_S: begin
                if (w_sof && (r_line_cnt != '0)) begin
                    // early SOF: hold the beat, let WAIT_SOF_S restart on it
                    w_abort     = 1'b1;
                    w_state_nxt = WAIT_SOF_S;
                end else begin
                    w_in_tready  = video_o_tready;
                    w_out_tvalid = video_i_tvalid;
                    if (video_i_tvalid && video_o_tready && video_i_tlast) begin
                        if (w_last_line) begin
                            w_frame_done = 1'b1;
                            w_state_nxt  = WAIT_SOF_S;
                        end else begin
                            w_line_adv = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = WAIT_SOF_S;
        endcase
    end

    // Line tracking, per-frame latches, address walk and status pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_line_first  <= 1'b1;
            r_line_cnt    <= '0;
            r_lines       <= '0;
            r_line_stride <= '0;
            r_addr        <= '0;
            r_pkt_size    <= '0;
            r_wr_slot     <= SLOT_W'(NUM_SLOTS - 1);
            r_done_slot   <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= w_frame_done;
            r_err  <= w_abort;
            if (w_hs_in) begin
                r_line_first <= video_i_tlast;
            end
            if (w_start) begin
                r_wr_slot     <= w_next_slot;
                r_addr        <= w_frame_addr;
                r_pkt_size    <= line_size_i;
                r_line_stride <= line_stride_i;
                r_lines       <= frame_lines_i;
                r_line_cnt    <= '0;
            end else if (w_line_adv) begin
                r_line_cnt <= r_line_cnt + LINES_WIDTH'(1);
                r_addr     <= r_addr + r_line_stride;
            end
            if (w_frame_done) begin
                r_done_slot <= r_wr_slot;
            end
        end
    end

endmodule

// File: tb/tb_fb_wr_scheduler.sv
// Directed bench for fb_wr_scheduler: slot rotation, address walk, pre-SOF
// discard, early-SOF abort, back-pressure and mid-frame reset.
module tb_fb_wr_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] vi_tdata;
    logic [7:0]  vi_tstrb;
    logic [7:0]  vi_tkeep;
    logic        vi_tlast;
    logic        vi_tuser;
    logic        vi_tvalid;
    logic        vi_tready;
    logic [63:0] vo_tdata;
    logic [7:0]  vo_tstrb;
    logic [7:0]  vo_tkeep;
    logic        vo_tlast;
    logic        vo_tuser;
    logic        vo_tvalid;
    logic        vo_tready;
    logic [31:0] base_addr_i;
    logic [31:0] frame_stride_i;
    logic [31:0] line_stride_i;
    logic [10:0] line_size_i;
    logic [11:0] frame_lines_i;
    logic [1:0]  rd_slot_i;
    logic [31:0] addr_o;
    logic [10:0] pkt_size_o;
    logic [1:0]  wr_slot_o;
    logic [1:0]  done_slot_o;
    logic        done_o;
    logic        err_o;

    fb_wr_scheduler dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .video_i_tdata  (vi_tdata),
        .video_i_tstrb  (vi_tstrb),
        .video_i_tkeep  (vi_tkeep),
        .video_i_tlast  (vi_tlast),
        .video_i_tuser  (vi_tuser),
        .video_i_tvalid (vi_tvalid),
        .video_i_tready (vi_tready),
        .video_o_tdata  (vo_tdata),
        .video_o_tstrb  (vo_tstrb),
        .video_o_tkeep  (vo_tkeep),
        .video_o_tlast  (vo_tlast),
        .video_o_tuser  (vo_tuser),
        .video_o_tvalid (vo_tvalid),
        .video_o_tready (vo_tready),
        .base_addr_i    (base_addr_i),
        .frame_stride_i (frame_stride_i),
        .line_stride_i  (line_stride_i),
        .line_size_i    (line_size_i),
        .frame_lines_i  (frame_lines_i),
        .rd_slot_i      (rd_slot_i),
        .addr_o         (addr_o),
        .pkt_size_o     (pkt_size_o),
        .wr_slot_o      (wr_slot_o),
        .done_slot_o    (done_slot_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad   = 0;
    int          n_done = 0;
    int          n_err  = 0;
    logic        rand_rdy = 1'b0;
    logic [31:0] seq = 32'd0;
    logic [63:0] exp_beat_q[$];
    logic [63:0] got_beat_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] got_addr_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Record every forwarded beat with the address presented alongside it
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (vo_tvalid && vo_tready) begin
                got_beat_q.push_back({14'd0, vo_tuser, vo_tlast, vo_tkeep, vo_tstrb, vo_tdata[31:0]});
                got_addr_q.push_back(addr_o);
            end
            if (done_o) n_done++;
            if (err_o)  n_err++;
        end
    end

    // One upstream beat; called and returns at posedge+1
    task automatic send_beat(input logic user, input logic last, input logic fwd, input logic [31:0] exp_addr);
        logic hs;
        hs = 1'b0;
        seq = seq + 32'd1;
        vi_tdata  = {seq ^ 32'hDEAD_BEEF, seq};
        vi_tkeep  = seq[7:0];
        vi_tstrb  = ~seq[7:0];
        vi_tuser  = user;
        vi_tlast  = last;
        vi_tvalid = 1'b1;
        if (fwd) begin
            exp_beat_q.push_back({14'd0, user, last, seq[7:0], ~seq[7:0], seq});
            exp_addr_q.push_back(exp_addr);
        end
        for (int n = 0; n < 64; n++) begin
            @(negedge clk_i);
            hs = vi_tready;
            @(posedge clk_i);
            #1;
            vo_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hs) break;
        end
        if (!hs) check_eq("beat_handshake", 64'(hs), 64'd1);
        vi_tvalid = 1'b0;
        vi_tuser  = 1'b0;
        vi_tlast  = 1'b0;
    endtask

    task automatic send_line(input int nb, input logic sof, input logic fwd, input logic [31:0] a);
        for (int i = 0; i < nb; i++) begin
            send_beat(sof && (i == 0), (i == nb - 1), fwd, a);
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic check_stream(input string tag);
        int errs;
        int n;
        errs = 0;
        check_eq({tag, "_beats"}, 64'(got_beat_q.size()), 64'(exp_beat_q.size()));
        n = (got_beat_q.size() < exp_beat_q.size()) ? got_beat_q.size() : exp_beat_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_beat_q[i] !== exp_beat_q[i]) errs++;
            if (got_addr_q[i] !== exp_addr_q[i]) errs++;
        end
        check_eq({tag, "_payload_addr"}, 64'(errs), 64'd0);
        got_beat_q.delete();
        exp_beat_q.delete();
        got_addr_q.delete();
        exp_addr_q.delete();
    endtask

    initial begin
        rst_i          = 1'b0;
        vi_tdata       = '0;
        vi_tstrb       = '0;
        vi_tkeep       = '0;
        vi_tlast       = 1'b0;
        vi_tuser       = 1'b0;
        vi_tvalid      = 1'b0;
        vo_tready      = 1'b1;
        base_addr_i    = 32'h1000_0000;
        frame_stride_i = 32'h0010_0000;
        line_stride_i  = 32'h0000_0800;
        line_size_i    = 11'd1920;
        frame_lines_i  = 12'd4;
        rd_slot_i      = 2'd2;

        #2 rst_i = 1'b1;
        vi_tvalid = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_addr",      64'(addr_o),      64'd0);
        check_eq("rst_pkt_size",  64'(pkt_size_o),  64'd0);
        check_eq("rst_wr_slot",   64'(wr_slot_o),   64'd2);
        check_eq("rst_done_slot", 64'(done_slot_o), 64'd0);
        check_eq("rst_done",      64'(done_o),      64'd0);
        check_eq("rst_err",       64'(err_o),       64'd0);
        check_eq("rst_vo_tvalid", 64'(vo_tvalid),   64'd0);
        check_eq("rst_vi_tready", 64'(vi_tready),   64'd1);
        vi_tvalid = 1'b0;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // lines before the first SOF are swallowed
        for (int l = 0; l < 3; l++) send_line(3, 1'b0, 1'b0, 32'h0);
        check_eq("presof_addr",    64'(addr_o),    64'd0);
        check_eq("presof_wr_slot", 64'(wr_slot_o), 64'd2);
        check_stream("presof");

        // frame 1: slot 0
        for (int l = 0; l < 4; l++) send_line(2, l == 0, 1'b1, 32'h1000_0000 + 32'(l) * 32'h800);
        settle();
        check_eq("f1_done_cnt",  64'(n_done),      64'd1);
        check_eq("f1_done_slot", 64'(done_slot_o), 64'd0);
        check_eq("f1_wr_slot",   64'(wr_slot_o),   64'd0);
        check_eq("f1_pkt_size",  64'(pkt_size_o),  64'd1920);
        check_stream("f1");

        // frame 2: slot 1
        for (int l = 0; l < 4; l++) send_line(2, l == 0, 1'b1, 32'h1010_0000 + 32'(l) * 32'h800);
        settle();
        check_eq("f2_done_cnt",  64'(n_done),      64'd2);
        check_eq("f2_done_slot", 64'(done_slot_o), 64'd1);
        check_stream("f2");

        // frame 3: reader holds slot 2, so wrap to slot 0
        frame_lines_i = 12'd2;
        for (int l = 0; l < 2; l++) send_line(2, l == 0, 1'b1, 32'h1000_0000 + 32'(l) * 32'h800);
        settle();
        check_eq("f3_done_cnt", 64'(n_done),    64'd3);
        check_eq("f3_wr_slot",  64'(wr_slot_o), 64'd0);
        check_stream("f3");

        // frame 4: reader holds slot 1 -> slot 2; mid-frame config changes ignored
        rd_slot_i = 2'd1;
        send_line(2, 1'b1, 1'b1, 32'h1020_0000);
        line_stride_i = 32'h40;
        frame_lines_i = 12'd4;
        base_addr_i   = 32'h2000_0000;
        rd_slot_i     = 2'd0;
        send_line(2, 1'b0, 1'b1, 32'h1020_0800);
        settle();
        check_eq("f4_done_cnt",  64'(n_done),      64'd4);
        check_eq("f4_done_slot", 64'(done_slot_o), 64'd2);
        check_eq("f4_wr_slot",   64'(wr_slot_o),   64'd2);
        check_stream("f4");
        line_stride_i = 32'h800;
        base_addr_i   = 32'h1000_0000;
        rd_slot_i     = 2'd2;

        // frame 5 aborted by SOF on line 2; frame 6 restarts on the held beat
        rand_rdy = 1'b1;
        send_line(2, 1'b1, 1'b1, 32'h1000_0000);
        send_line(2, 1'b0, 1'b1, 32'h1000_0800);
        send_line(2, 1'b1, 1'b1, 32'h1010_0000);
        check_eq("abort_err_cnt",   64'(n_err),       64'd1);
        check_eq("abort_done_cnt",  64'(n_done),      64'd4);
        check_eq("abort_done_slot", 64'(done_slot_o), 64'd2);
        check_eq("abort_wr_slot",   64'(wr_slot_o),   64'd1);
        for (int l = 1; l < 4; l++) send_line(3, 1'b0, 1'b1, 32'h1010_0000 + 32'(l) * 32'h800);
        settle();
        check_eq("f6_done_cnt",  64'(n_done),      64'd5);
        check_eq("f6_err_cnt",   64'(n_err),       64'd1);
        check_eq("f6_done_slot", 64'(done_slot_o), 64'd1);
        check_stream("f6");
        rand_rdy  = 1'b0;
        vo_tready = 1'b1;

        // frame 7 cut by reset mid line 1
        rd_slot_i = 2'd0;
        send_line(2, 1'b1, 1'b1, 32'h1020_0000);
        send_beat(1'b0, 1'b0, 1'b1, 32'h1020_0800);
        check_eq("f7_addr", 64'(addr_o), 64'h1020_0800);
        vi_tvalid = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        check_eq("mid_rst_addr",      64'(addr_o),      64'd0);
        check_eq("mid_rst_wr_slot",   64'(wr_slot_o),   64'd2);
        check_eq("mid_rst_done_slot", 64'(done_slot_o), 64'd0);
        check_eq("mid_rst_pkt_size",  64'(pkt_size_o),  64'd0);
        check_eq("mid_rst_vo_tvalid", 64'(vo_tvalid),   64'd0);
        vi_tvalid = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_eq("mid_rst_done_cnt", 64'(n_done), 64'd5);
        check_eq("mid_rst_err_cnt",  64'(n_err),  64'd1);

        // frame 8: one-line frame lands in slot 0
        rd_slot_i     = 2'd2;
        frame_lines_i = 12'd1;
        line_size_i   = 11'd1000;
        send_line(3, 1'b1, 1'b1, 32'h1000_0000);
        settle();
        check_eq("f8_done_cnt",  64'(n_done),      64'd6);
        check_eq("f8_done_slot", 64'(done_slot_o), 64'd0);
        check_eq("f8_wr_slot",   64'(wr_slot_o),   64'd0);
        check_eq("f8_pkt_size",  64'(pkt_size_o),  64'd1000);
        check_eq("f8_done_low",  64'(done_o),      64'd0);
        check_stream("f8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_wr_scheduler.md
FB_WR_SCHEDULER -- requirements
Module: fb_wr_scheduler

Interface
REQ-001 Parameters: DATA_WIDTH, default 64, stream/burst data width in bits.
REQ-002 Parameters: ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameters: MAX_PKT_SIZE_WIDTH, default 11, line size field width in bytes.
REQ-004 Parameters: LINES_WIDTH, default 12, line counter width.
REQ-005 Parameters: NUM_SLOTS, default 3, frame slots in memory, minimum 3.
REQ-006 Ports: clk_i, input, 1, single clock; rst_i, input, 1, asynchronous, active-high reset.
REQ-007 Ports: video_i, axi4_stream_if.slave, DATA_WIDTH, upstream video (tuser = start of frame, tlast = end of line).
REQ-008 Ports: video_o, axi4_stream_if.master, DATA_WIDTH, to stream-to-burst writer.
REQ-009 Ports: base_addr_i, input, ADDR_WIDTH, slot 0 byte address; frame_stride_i, input, ADDR_WIDTH, bytes between slots; line_stride_i, input, ADDR_WIDTH, bytes between lines.
REQ-010 Ports: line_size_i, input, MAX_PKT_SIZE_WIDTH, line bytes; frame_lines_i, input, LINES_WIDTH, lines per frame (≥1).
REQ-011 Ports: rd_slot_i, input, clog2(NUM_SLOTS), slot held by reader.
REQ-012 Ports: addr_o, output, ADDR_WIDTH, current line address; pkt_size_o, output, MAX_PKT_SIZE_WIDTH, current line size.
REQ-013 Ports: wr_slot_o, output, clog2(NUM_SLOTS), slot being written; done_slot_o, output, same width, last completed slot; done_o, output, 1, one-cycle frame-complete pulse; err_o, output, 1, one-cycle aborted-frame pulse.

Function
REQ-014 States: WAIT_SOF_S, RUN_S; line_first flag is set on reset and after any video_i tlast handshake, and cleared by any other video_i handshake.
REQ-015 WAIT_SOF_S: video_o.tvalid=0; video_i.tready=1 except when video_i.tvalid && tuser && line_first; such beats are discarded.
REQ-016 WAIT_SOF_S with video_i.tvalid && tuser && line_first: in that cycle, do not consume the beat; register next slot, latch line_size_i, line_stride_i, frame_lines_i; set addr_o=base_addr_i+slot*frame_stride_i; line_cnt=0; go RUN_S.
REQ-017 Next slot = (wr_slot_o+1) mod NUM_SLOTS; if equal to rd_slot_i, use (wr_slot_o+2) mod NUM_SLOTS.
REQ-018 RUN_S: video_o carries tdata/tstrb/tkeep/tlast/tuser unchanged with tvalid=video_i.tvalid and video_i.tready=video_o.tready (zero latency, no buffering).
REQ-019 RUN_S tlast handshake with line_cnt < latched_lines-1: line_cnt+1, addr_o+=latched line_stride, effective next cycle.
REQ-020 RUN_S tlast handshake with line_cnt == latched_lines-1: done_o=1 next cycle, done_slot_o=wr_slot_o, go WAIT_SOF_S.
REQ-021 RUN_S, video_i.tvalid && tuser && line_first && line_cnt != 0 (early SOF): video_o.tvalid=0 and video_i.tready=0 that cycle; err_o=1 next cycle; done_slot_o unchanged; go WAIT_SOF_S (which restarts on the same held beat next cycle).
REQ-022 tuser on the first line of RUN_S (line_cnt == 0) is passed through, not an error.
REQ-023 addr_o, pkt_size_o, wr_slot_o change only at REQ-016/REQ-019 events, so they are stable while video_o holds a line's first beat.
REQ-024 All address arithmetic is modulo 2^ADDR_WIDTH; no alignment is applied (writer aligns).
REQ-025 Config input changes during RUN_S have no effect until next frame start.
REQ-026 rd_slot_i is sampled only at frame start.

Reset
REQ-027 rst_i asserted: state=WAIT_SOF_S, line_first=1, line_cnt=0, addr_o=0, pkt_size_o=0, wr_slot_o=NUM_SLOTS-1, done_slot_o=0, done_o=0, err_o=0, video_o.tvalid=0.
REQ-028 Reset mid-frame abandons the frame without done_o or err_o; the first slot after reset is 0, or 1 if rd_slot_i=0.

Verification
REQ-029 base=0x1000_0000, frame_stride=0x10_0000, line_stride=0x800, size=1920, lines=4, rd_slot=2, two frames -> first frame addr_o 0x1000_0000..0x1000_1800, done_o with done_slot_o=0; second frame at slot 1, 0x1010_0000.
REQ-030 rd_slot_i=1 at start of second frame (wr_slot=0) -> slot 2 selected, addr_o=base+0x20_0000.
REQ-031 Three lines without tuser before the first SOF -> all beats accepted with video_o.tvalid=0, no address change; capture begins on the tuser beat.
REQ-032 tuser at start of line 2 of 4 -> err_o single pulse, no done_o, new frame starts in the next slot at line 0, held beat forwarded exactly once.
REQ-033 video_o.tready toggled randomly -> no beats lost or duplicated; addr_o constant within every line.
REQ-034 rst_i pulsed mid-line 1 -> outputs at REQ-027 values immediately; next SOF writes slot 0.
